// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame-checker FSM states,
// parity-type encodings and the supported data-width range.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_rx_sat_counter.sv
// Error counter that counts up by one per INC and sticks at all-ones;
// CLR takes priority over INC.
module uart_rx_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             INC,
  output logic [WIDTH-1:0] CNT
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CNT <= '0;
    end else if (CLR) begin
      CNT <= '0;
    end else if (INC && (CNT != {WIDTH{1'b1}})) begin
      CNT <= CNT + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// Receive-side frame checker: assembles an LSB-first data word from sampled
// bits, checks optional parity and the stop bit, and tracks error statistics.
module uart_rx_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FRAME_START,
  input  logic                  BIT_VALID,
  input  logic                  BIT_VAL,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYPE,
  input  logic                  ERR_CLR,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  PARITY_ERROR,
  output logic                  FRAME_ERROR,
  output logic                  PAR_ERR_STICKY,
  output logic                  FRM_ERR_STICKY,
  output logic [CNT_WIDTH-1:0]  PAR_ERR_CNT,
  output logic [CNT_WIDTH-1:0]  FRM_ERR_CNT,
  output logic                  BUSY,
  output logic [1:0]            STATE_DBG
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  // Handshake: BIT_VALID is a one-cycle strobe with no back-pressure. BIT_VAL
  // is consumed on every cycle BIT_VALID is high in DATA/PARITY/STOP and is
  // ignored in IDLE; FRAME_START overrides any strobe in the same cycle.
  state_e                state, state_nxt;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  acc;
  logic                  par_en_q;
  logic                  par_type_q;
  logic                  frame_done;
  logic                  par_err_now;
  logic                  frm_err_now;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    if (FRAME_START) begin
      state_nxt = DATA;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        DATA: begin
          if (BIT_VALID && (bit_cnt == BCW'(DATA_WIDTH - 1))) begin
            state_nxt = par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (BIT_VALID) begin
            state_nxt = STOP;
          end
        end
        STOP: begin
          if (BIT_VALID) begin
            state_nxt  = IDLE;
            frame_done = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Accumulator holds the XOR of all data bits and the parity bit.
  assign par_err_now = par_en_q & ((par_type_q == PAR_ODD) ? ~acc : acc);
  assign frm_err_now = ~BIT_VAL;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      acc        <= 1'b0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
    end else if (FRAME_START) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      acc        <= 1'b0;
      par_en_q   <= PAR_EN;
      par_type_q <= PAR_TYPE;
    end else if (BIT_VALID && (state == DATA)) begin
      shift_reg <= {BIT_VAL, shift_reg[DATA_WIDTH-1:1]};
      acc       <= acc ^ BIT_VAL;
      bit_cnt   <= bit_cnt + 1'b1;
    end else if (BIT_VALID && (state == PARITY)) begin
      acc <= acc ^ BIT_VAL;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DATA_VALID   <= 1'b0;
      DATA_OUT     <= '0;
      PARITY_ERROR <= 1'b0;
      FRAME_ERROR  <= 1'b0;
    end else begin
      DATA_VALID <= frame_done;
      if (frame_done) begin
        DATA_OUT     <= shift_reg;
        PARITY_ERROR <= par_err_now;
        FRAME_ERROR  <= frm_err_now;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PAR_ERR_STICKY <= 1'b0;
      FRM_ERR_STICKY <= 1'b0;
    end else if (ERR_CLR) begin
      PAR_ERR_STICKY <= 1'b0;
      FRM_ERR_STICKY <= 1'b0;
    end else if (frame_done) begin
      if (par_err_now) PAR_ERR_STICKY <= 1'b1;
      if (frm_err_now) FRM_ERR_STICKY <= 1'b1;
    end
  end

  uart_rx_sat_counter #(.WIDTH(CNT_WIDTH)) u_par_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (ERR_CLR),
    .INC (frame_done & par_err_now),
    .CNT (PAR_ERR_CNT)
  );

  uart_rx_sat_counter #(.WIDTH(CNT_WIDTH)) u_frm_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (ERR_CLR),
    .INC (frame_done & frm_err_now),
    .CNT (FRM_ERR_CNT)
  );

  assign BUSY      = (state != IDLE);
  assign STATE_DBG = state;

endmodule
